// File: rtl/trace_line_parser_if.sv
// Handshake bundle for trace_line_parser: ASCII byte input, hex nibble
// strobe, {op, address} command output and the malformed-line pulse.
// Instantiate with the same ADDR_W as the parser it connects to.
interface trace_line_parser_if #(
    parameter int ADDR_W = 32
);
    logic [7:0]        char_in;
    logic              char_valid;
    logic              char_ready;
    logic [3:0]        hex_nib;
    logic              hex_stb;
    logic [3:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_addr;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              line_err;

    // Parser side: consumes bytes, produces nibbles, commands and errors.
    modport master (
        input  char_in, char_valid, cmd_ready,
        output char_ready, hex_nib, hex_stb, cmd_op, cmd_addr, cmd_valid, line_err
    );

    // Environment side: byte source and command sink.
    modport slave (
        output char_in, char_valid, cmd_ready,
        input  char_ready, hex_nib, hex_stb, cmd_op, cmd_addr, cmd_valid, line_err
    );
endinterface

// File: rtl/trace_line_parser.sv
// trace_line_parser: front end of the trace-driven cache model.
// Parses ASCII lines "<op digit> <hex address>\n" into {op, address}
// commands on a valid/ready handshake, strobes every accumulated address
// digit out as a nibble, and drops malformed lines with a one-cycle
// line_err pulse. CR is ignored everywhere; space/tab are whitespace.
// Build option: define TRACE_PARSER_ERR_CNT_EN to add the saturating
// err_count / line_count status outputs.
module trace_line_parser #(
    parameter int ADDR_W     = 32,
    parameter int MAX_DIGITS = ADDR_W / 4
) (
    input  logic                clk,
    input  logic                reset,
    trace_line_parser_if.master bus
`ifdef TRACE_PARSER_ERR_CNT_EN
    ,
    output logic [15:0]         err_count,
    output logic [15:0]         line_count
`endif
);

    localparam int               CNT_W   = $clog2(MAX_DIGITS + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_DIGITS);

    // Line-parser states
    localparam logic [2:0] S_IDLE  = 3'd0;  // waiting for the op digit
    localparam logic [2:0] S_OPSEP = 3'd1;  // op seen, need whitespace
    localparam logic [2:0] S_ADDR0 = 3'd2;  // separator seen, no digit yet
    localparam logic [2:0] S_ADDR  = 3'd3;  // collecting address digits
    localparam logic [2:0] S_TAIL  = 3'd4;  // trailing whitespace before LF
    localparam logic [2:0] S_ERR   = 3'd5;  // bad line, discard until LF
    localparam logic [2:0] S_EMIT  = 3'd6;  // command presented downstream

    localparam logic [7:0] CH_TAB   = 8'h09;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_SP    = 8'h20;
    localparam logic [7:0] CH_0     = 8'h30;
    localparam logic [7:0] CH_9     = 8'h39;
    localparam logic [7:0] CH_UP_A  = 8'h41;
    localparam logic [7:0] CH_UP_F  = 8'h46;
    localparam logic [7:0] CH_LOW_A = 8'h61;
    localparam logic [7:0] CH_LOW_F = 8'h66;

    logic [2:0]        state_reg, state_next;
    logic [ADDR_W-1:0] acc_reg,   acc_next;
    logic [CNT_W-1:0]  count_reg, count_next;
    logic [3:0]        op_reg,    op_next;
    logic [3:0]        nib_reg,   nib_next;
    logic              stb_reg,   stb_next;
    logic              err_reg,   err_next;

    logic       char_ready;
    logic       accept;
    logic       handshake;
    logic       do_acc;
    logic       is_cr, is_lf, is_ws, is_dec, is_hex;
    logic [3:0] hex_val;

    // Back-pressure the byte stream only while a command waits, and during reset.
    assign char_ready = !reset && (state_reg != S_EMIT);
    assign accept     = bus.char_valid && char_ready;
    assign handshake  = (state_reg == S_EMIT) && bus.cmd_ready;

    // Classify the incoming byte and decode its hex value.
    always_comb begin
        is_cr   = (bus.char_in == CH_CR);
        is_lf   = (bus.char_in == CH_LF);
        is_ws   = (bus.char_in == CH_SP) || (bus.char_in == CH_TAB);
        is_dec  = (bus.char_in >= CH_0) && (bus.char_in <= CH_9);
        is_hex  = 1'b0;
        hex_val = 4'h0;
        if (is_dec) begin
            is_hex  = 1'b1;
            hex_val = bus.char_in[3:0];
        end else if ((bus.char_in >= CH_LOW_A) && (bus.char_in <= CH_LOW_F)) begin
            is_hex  = 1'b1;
            hex_val = bus.char_in[3:0] + 4'd9;
        end else if ((bus.char_in >= CH_UP_A) && (bus.char_in <= CH_UP_F)) begin
            is_hex  = 1'b1;
            hex_val = bus.char_in[3:0] + 4'd9;
        end
    end

    // Next-state and datapath decisions for one accepted byte.
    always_comb begin
        state_next = state_reg;
        acc_next   = acc_reg;
        count_next = count_reg;
        op_next    = op_reg;
        nib_next   = nib_reg;
        stb_next   = 1'b0;
        err_next   = 1'b0;
        do_acc     = 1'b0;

        if (state_reg == S_EMIT) begin
            if (bus.cmd_ready) begin
                state_next = S_IDLE;
            end
        end else if (accept && !is_cr) begin
            case (state_reg)
                S_IDLE: begin
                    if (is_ws || is_lf) begin
                        state_next = S_IDLE;
                    end else if (is_dec) begin
                        op_next    = bus.char_in[3:0];
                        acc_next   = '0;
                        count_next = '0;
                        state_next = S_OPSEP;
                    end else begin
                        state_next = S_ERR;
                    end
                end
                S_OPSEP: begin
                    if (is_ws) begin
                        state_next = S_ADDR0;
                    end else if (is_lf) begin
                        err_next   = 1'b1;
                        state_next = S_IDLE;
                    end else begin
                        state_next = S_ERR;
                    end
                end
                S_ADDR0: begin
                    if (is_ws) begin
                        state_next = S_ADDR0;
                    end else if (is_hex) begin
                        do_acc     = 1'b1;
                        state_next = S_ADDR;
                    end else if (is_lf) begin
                        err_next   = 1'b1;
                        state_next = S_IDLE;
                    end else begin
                        state_next = S_ERR;
                    end
                end
                S_ADDR: begin
                    if (is_hex) begin
                        // An over-long address is dropped without strobing the extra digit.
                        if (count_reg < MAX_CNT) begin
                            do_acc = 1'b1;
                        end else begin
                            state_next = S_ERR;
                        end
                    end else if (is_ws) begin
                        state_next = S_TAIL;
                    end else if (is_lf) begin
                        state_next = S_EMIT;
                    end else begin
                        state_next = S_ERR;
                    end
                end
                S_TAIL: begin
                    if (is_ws) begin
                        state_next = S_TAIL;
                    end else if (is_lf) begin
                        state_next = S_EMIT;
                    end else begin
                        state_next = S_ERR;
                    end
                end
                S_ERR: begin
                    if (is_lf) begin
                        err_next   = 1'b1;
                        state_next = S_IDLE;
                    end
                end
                default: begin
                    state_next = S_IDLE;
                end
            endcase
        end

        if (do_acc) begin
            acc_next   = (acc_reg << 4) | ADDR_W'(hex_val);
            count_next = count_reg + 1'b1;
            nib_next   = hex_val;
            stb_next   = 1'b1;
        end
    end

    // Register parser state, accumulator and the one-cycle output pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= S_IDLE;
            acc_reg   <= '0;
            count_reg <= '0;
            op_reg    <= 4'h0;
            nib_reg   <= 4'h0;
            stb_reg   <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            acc_reg   <= acc_next;
            count_reg <= count_next;
            op_reg    <= op_next;
            nib_reg   <= nib_next;
            stb_reg   <= stb_next;
            err_reg   <= err_next;
        end
    end

    assign bus.char_ready = char_ready;
    assign bus.hex_nib    = nib_reg;
    assign bus.hex_stb    = stb_reg;
    assign bus.cmd_op     = op_reg;
    assign bus.cmd_addr   = acc_reg;
    assign bus.cmd_valid  = (state_reg == S_EMIT);
    assign bus.line_err   = err_reg;

`ifdef TRACE_PARSER_ERR_CNT_EN
    logic [15:0] err_count_reg;
    logic [15:0] line_count_reg;

    // Saturating counts of dropped lines and delivered commands.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_count_reg  <= 16'h0000;
            line_count_reg <= 16'h0000;
        end else begin
            if (err_next && (err_count_reg != 16'hFFFF)) begin
                err_count_reg <= err_count_reg + 16'd1;
            end
            if (handshake && (line_count_reg != 16'hFFFF)) begin
                line_count_reg <= line_count_reg + 16'd1;
            end
        end
    end

    assign err_count  = err_count_reg;
    assign line_count = line_count_reg;
`endif

endmodule

// File: tb/tb_trace_line_parser.sv
// Testbench for trace_line_parser: table of directed lines with
// hand-computed results, hand-written backpressure and reset sequences,
// then random lines checked against a string-level reference parser.
`timescale 1ns/1ps
module tb_trace_line_parser;

    localparam int ADDR_W     = 32;
    localparam int MAX_DIGITS = ADDR_W / 4;
    localparam logic [7:0] LF = 8'h0A;
    localparam logic [7:0] CR = 8'h0D;

    typedef logic [7:0] bq_t[$];

    typedef struct {
        string       line;
        int          n_cmd;
        logic [3:0]  op;
        logic [31:0] addr;
        int          n_err;
        int          n_nib;
        logic [31:0] word;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    trace_line_parser_if #(.ADDR_W(ADDR_W)) bus ();

`ifdef TRACE_PARSER_ERR_CNT_EN
    logic [15:0] err_count;
    logic [15:0] line_count;
`endif

    trace_line_parser #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus)
`ifdef TRACE_PARSER_ERR_CNT_EN
        ,
        .err_count  (err_count),
        .line_count (line_count)
`endif
    );

    int checks   = 0;
    int failures = 0;
    int exp_err_tot = 0;
    int exp_cmd_tot = 0;
    bit rand_ready  = 1'b0;

    // Events observed by the monitor for the line in flight.
    int          seen_nib, seen_err, seen_cmd;
    logic [31:0] nib_word;
    logic [3:0]  last_op;
    logic [31:0] last_addr;
    bit          hold_prev = 1'b0;
    logic [3:0]  hold_op;
    logic [31:0] hold_addr;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    // Monitor: collect strobes, error pulses, handshakes; check hold stability.
    always @(negedge clk) begin
        if (reset) begin
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                check("hold_valid", bus.cmd_valid, 1);
                check("hold_op",    bus.cmd_op,    hold_op);
                check("hold_addr",  bus.cmd_addr,  hold_addr);
            end
            if (bus.hex_stb) begin
                seen_nib++;
                nib_word = {nib_word[27:0], bus.hex_nib};
            end
            if (bus.line_err) seen_err++;
            if (bus.cmd_valid && bus.cmd_ready) begin
                seen_cmd++;
                last_op   = bus.cmd_op;
                last_addr = bus.cmd_addr;
            end
            hold_prev = bus.cmd_valid && !bus.cmd_ready;
            hold_op   = bus.cmd_op;
            hold_addr = bus.cmd_addr;
        end
    end

    // Random consumer back-pressure during the random phase.
    always @(posedge clk) begin
        if (rand_ready) begin
            #1;
            bus.cmd_ready = ($urandom_range(0, 2) != 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic bq_t to_q(input string s);
        bq_t q;
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
        return q;
    endfunction

    function automatic void add_vec(input string l, input int nc, input logic [3:0] op,
                                    input logic [31:0] a, input int ne, input int nn,
                                    input logic [31:0] w);
        vec_t v;
        v.line = l; v.n_cmd = nc; v.op = op; v.addr = a;
        v.n_err = ne; v.n_nib = nn; v.word = w;
        vecs.push_back(v);
    endfunction

    function automatic bit is_ws(input logic [7:0] b);
        return (b == 8'h20) || (b == 8'h09);
    endfunction

    function automatic bit is_dec(input logic [7:0] b);
        return (b >= 8'h30) && (b <= 8'h39);
    endfunction

    function automatic bit is_hexc(input logic [7:0] b);
        return is_dec(b) || ((b >= 8'h61) && (b <= 8'h66)) || ((b >= 8'h41) && (b <= 8'h46));
    endfunction

    function automatic logic [3:0] hexv(input logic [7:0] b);
        if (is_dec(b)) return 4'(b - 8'h30);
        if (b >= 8'h61) return 4'(b - 8'h61 + 8'd10);
        return 4'(b - 8'h41 + 8'd10);
    endfunction

    function automatic logic [7:0] rand_ws();
        return ($urandom_range(0, 1) != 0) ? 8'h20 : 8'h09;
    endfunction

    function automatic logic [7:0] rand_hex();
        int v;
        v = $urandom_range(0, 15);
        if (v < 10) return 8'h30 + 8'(v);
        return (($urandom_range(0, 1) != 0) ? 8'h61 : 8'h41) + 8'(v - 10);
    endfunction

    // Reference: parse one whole line as text (CRs removed, LF stripped).
    task automatic model_line(input bq_t q, output int n_cmd, output logic [3:0] op,
                              output logic [31:0] addr, output int n_err,
                              output int n_nib, output logic [31:0] word);
        bq_t t;
        int  p;
        int  tok_len;
        n_cmd = 0; op = 4'h0; addr = 32'h0; n_err = 0; n_nib = 0; word = 32'h0;
        foreach (q[i]) if (q[i] != CR && q[i] != LF) t.push_back(q[i]);
        p = 0;
        while (p < t.size() && is_ws(t[p])) p++;
        if (p == t.size()) return;
        if (!is_dec(t[p])) begin n_err = 1; return; end
        op = hexv(t[p]);
        p++;
        if (p >= t.size() || !is_ws(t[p])) begin n_err = 1; return; end
        while (p < t.size() && is_ws(t[p])) p++;
        tok_len = 0;
        while (p < t.size() && is_hexc(t[p])) begin
            if (tok_len < MAX_DIGITS) begin
                n_nib++;
                word = {word[27:0], hexv(t[p])};
            end
            tok_len++;
            p++;
        end
        if (tok_len == 0 || tok_len > MAX_DIGITS) begin n_err = 1; return; end
        while (p < t.size() && is_ws(t[p])) p++;
        if (p != t.size()) begin n_err = 1; return; end
        n_cmd = 1;
        addr  = word;
    endtask

    task automatic gen_line(output bq_t q);
        int r;
        int v;
        int nd;
        q = {};
        r = $urandom_range(0, 99);
        if (r < 8) begin
            repeat ($urandom_range(0, 3)) q.push_back(rand_ws());
        end else begin
            if ($urandom_range(0, 3) == 0) q.push_back(rand_ws());
            if ($urandom_range(0, 19) == 0) q.push_back(8'h78);
            else begin
                v = $urandom_range(0, 9);
                q.push_back(8'h30 + 8'(v));
            end
            if ($urandom_range(0, 19) == 0) q.push_back(8'h35);
            if ($urandom_range(0, 19) != 0) repeat ($urandom_range(1, 2)) q.push_back(rand_ws());
            nd = ($urandom_range(0, 19) == 0) ? 0 : $urandom_range(1, MAX_DIGITS + 2);
            repeat (nd) q.push_back(rand_hex());
            if ($urandom_range(0, 19) == 0) q.push_back(8'h67);
            repeat ($urandom_range(0, 2)) q.push_back(rand_ws());
            if ($urandom_range(0, 19) == 0) q.push_back(rand_hex());
        end
        if ($urandom_range(0, 3) == 0) q.insert($urandom_range(0, q.size()), CR);
        q.push_back(LF);
    endtask

    task automatic clear_seen();
        seen_nib = 0; seen_err = 0; seen_cmd = 0;
        nib_word = 32'h0; last_op = 4'h0; last_addr = 32'h0;
    endtask

    // Offer one byte until accepted; returns 1 ns after the accepting edge.
    task automatic send_byte(input logic [7:0] b);
        int guard;
        guard = 0;
        bus.char_in    = b;
        bus.char_valid = 1'b1;
        @(negedge clk);
        while (!bus.char_ready && guard < 200) begin
            guard++;
            @(negedge clk);
        end
        if (guard >= 200) timeout_fail("char_ready_wait");
        @(posedge clk);
        #1;
        bus.char_valid = 1'b0;
    endtask

    task automatic send_line(input bq_t q, input bit gaps);
        foreach (q[i]) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            send_byte(q[i]);
        end
    endtask

    // Wait for any pending command to drain and trailing pulses to settle.
    task automatic drain();
        int guard;
        guard = 0;
        @(negedge clk);
        while (bus.cmd_valid && guard < 100) begin
            guard++;
            @(negedge clk);
        end
        if (guard >= 100) timeout_fail("cmd_drain");
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic compare_line(input string tag, input int e_cmd, input logic [3:0] e_op,
                                input logic [31:0] e_addr, input int e_err,
                                input int e_nib, input logic [31:0] e_word);
        check({tag, "_cmds"}, seen_cmd, e_cmd);
        if (e_cmd != 0 && seen_cmd != 0) begin
            check({tag, "_op"},   last_op,   e_op);
            check({tag, "_addr"}, last_addr, e_addr);
        end
        check({tag, "_errs"}, seen_err, e_err);
        check({tag, "_nibs"}, seen_nib, e_nib);
        check({tag, "_nibword"}, nib_word, e_word);
        exp_err_tot += e_err;
        exp_cmd_tot += e_cmd;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_char_ready"}, bus.char_ready, 0);
        check({tag, "_hex_nib"},    bus.hex_nib,    0);
        check({tag, "_hex_stb"},    bus.hex_stb,    0);
        check({tag, "_cmd_op"},     bus.cmd_op,     0);
        check({tag, "_cmd_addr"},   bus.cmd_addr,   0);
        check({tag, "_cmd_valid"},  bus.cmd_valid,  0);
        check({tag, "_line_err"},   bus.line_err,   0);
`ifdef TRACE_PARSER_ERR_CNT_EN
        check({tag, "_err_count"},  err_count,  0);
        check({tag, "_line_count"}, line_count, 0);
`endif
    endtask

    initial begin
        bq_t         q;
        int          e_cmd, e_err, e_nib;
        logic [3:0]  e_op;
        logic [31:0] e_addr, e_word;

        // Directed vectors: line, cmds, op, addr, errs, strobes, strobed nibbles.
        add_vec("2 1A3F\n",              1, 4'd2, 32'h0000_1A3F, 0, 4, 32'h0000_1A3F);
        add_vec("0 ffffFFFF\015\n",      1, 4'd0, 32'hFFFF_FFFF, 0, 8, 32'hFFFF_FFFF);
        add_vec("\n\n7 0\n",             1, 4'd7, 32'h0000_0000, 0, 1, 32'h0000_0000);
        add_vec("9 123456789\n",         0, 4'd0, 32'h0,         1, 8, 32'h1234_5678);
        add_vec("1 10\n",                1, 4'd1, 32'h0000_0010, 0, 2, 32'h0000_0010);
        add_vec("x 10\n",                0, 4'd0, 32'h0,         1, 0, 32'h0);
        add_vec("3\n",                   0, 4'd0, 32'h0,         1, 0, 32'h0);
        add_vec("3 1g\n",                0, 4'd0, 32'h0,         1, 1, 32'h0000_0001);
        add_vec("34 5\n",                0, 4'd0, 32'h0,         1, 0, 32'h0);
        add_vec("5\t \tab \t\015\n",     1, 4'd5, 32'h0000_00AB, 0, 2, 32'h0000_00AB);
        add_vec("6 00000001\n",          1, 4'd6, 32'h0000_0001, 0, 8, 32'h0000_0001);
        add_vec(" \t 4 c\n",             1, 4'd4, 32'h0000_000C, 0, 1, 32'h0000_000C);
        add_vec("8  \n",                 0, 4'd0, 32'h0,         1, 0, 32'h0);
        add_vec("3 12 4\n",              0, 4'd0, 32'h0,         1, 2, 32'h0000_0012);
        add_vec("\015\n",                0, 4'd0, 32'h0,         0, 0, 32'h0);

        reset          = 1'b1;
        bus.char_in    = 8'h00;
        bus.char_valid = 1'b0;
        bus.cmd_ready  = 1'b1;
        clear_seen();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("init");
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("init_char_ready_after_reset", bus.char_ready, 1);
        @(posedge clk);
        #1;

        // Table-driven directed lines.
        foreach (vecs[i]) begin
            clear_seen();
            send_line(to_q(vecs[i].line), 1'b0);
            drain();
            compare_line($sformatf("v%0d", i), vecs[i].n_cmd, vecs[i].op, vecs[i].addr,
                         vecs[i].n_err, vecs[i].n_nib, vecs[i].word);
        end
`ifdef TRACE_PARSER_ERR_CNT_EN
        check("tbl_err_count",  err_count,  exp_err_tot);
        check("tbl_line_count", line_count, exp_cmd_tot);
`endif

        // Backpressure: command held while the next line's first byte waits.
        clear_seen();
        bus.cmd_ready = 1'b0;
        send_line(to_q("1 10\n"), 1'b0);
        bus.char_in    = 8'h32;
        bus.char_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("bp%0d_char_ready", k), bus.char_ready, 0);
            check($sformatf("bp%0d_cmd_valid", k),  bus.cmd_valid,  1);
            check($sformatf("bp%0d_cmd_op", k),     bus.cmd_op,     1);
            check($sformatf("bp%0d_cmd_addr", k),   bus.cmd_addr,   32'h10);
        end
        @(posedge clk);
        #1;
        bus.cmd_ready = 1'b1;
        @(negedge clk);
        check("bp_hs_cmd_valid",  bus.cmd_valid,  1);
        check("bp_hs_char_ready", bus.char_ready, 0);
        @(negedge clk);
        check("bp_post_cmd_valid",  bus.cmd_valid,  0);
        check("bp_post_char_ready", bus.char_ready, 1);
        @(posedge clk);
        #1;
        bus.char_valid = 1'b0;
        check("bp_cmds", seen_cmd, 1);
        check("bp_op",   last_op,  1);
        check("bp_addr", last_addr, 32'h10);
        exp_cmd_tot += 1;
        clear_seen();
        send_line(to_q(" 5\n"), 1'b0);
        drain();
        compare_line("bp_next", 1, 4'd2, 32'h5, 0, 1, 32'h5);

        // Reset in the middle of a line discards it.
        clear_seen();
        send_line(to_q("4 AB"), 1'b0);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("midrst");
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_err_tot = 0;
        exp_cmd_tot = 0;
        clear_seen();
        send_line(to_q("5 C\n"), 1'b0);
        drain();
        compare_line("after_rst", 1, 4'd5, 32'hC, 0, 1, 32'hC);

        // Random lines against the reference parser, with random back-pressure.
        rand_ready = 1'b1;
        for (int n = 0; n < 150; n++) begin
            gen_line(q);
            model_line(q, e_cmd, e_op, e_addr, e_err, e_nib, e_word);
            clear_seen();
            send_line(q, 1'b1);
            drain();
            compare_line($sformatf("r%0d", n), e_cmd, e_op, e_addr, e_err, e_nib, e_word);
        end
        rand_ready = 1'b0;
        @(posedge clk);
        #2;
        bus.cmd_ready = 1'b1;
`ifdef TRACE_PARSER_ERR_CNT_EN
        check("final_err_count",  err_count,  exp_err_tot);
        check("final_line_count", line_count, exp_cmd_tot);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
